worker_dispatcher: RTL and testbench

WORKER_DISPATCHER -- requirements
Module: worker_dispatcher

---
 rtl/worker_dispatch_pkg.sv | 16 +
 rtl/worker_dispatcher_if.sv | 31 +++
 rtl/worker_slot.sv | 62 ++++++
 rtl/worker_dispatcher.sv | 80 ++++++++
 tb/tb_worker_dispatcher.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/worker_dispatch_pkg.sv
// Shared defaults, slot state encoding and counter width for the worker dispatcher.
package worker_dispatch_pkg;

    localparam int NUM_WORKERS_DEF = 4;
    localparam int TASK_W_DEF      = 8;
    localparam int LEN_W_DEF       = 4;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } slot_state_e;

endpackage

// File: rtl/worker_dispatcher_if.sv
// Task intake, dispatch and per-worker status bundle between upstream and the dispatcher.
interface worker_dispatcher_if
    import worker_dispatch_pkg::*;
#(
    parameter int NUM_WORKERS = NUM_WORKERS_DEF,
    parameter int TASK_W      = TASK_W_DEF,
    parameter int LEN_W       = LEN_W_DEF
) ();

    logic                   task_valid;
    logic [TASK_W-1:0]      task_data;
    logic [LEN_W-1:0]       task_len;
    logic                   task_ready;
    logic [NUM_WORKERS-1:0] active_mask;
    logic [NUM_WORKERS-1:0] disp_valid;
    logic [TASK_W-1:0]      disp_data;
    logic [NUM_WORKERS-1:0] busy;
    logic [NUM_WORKERS-1:0] gate_ok;
    logic [CNT_W-1:0]       task_count;

    modport master (
        output task_valid, task_data, task_len, active_mask,
        input  task_ready, disp_valid, disp_data, busy, gate_ok, task_count
    );

    modport slave (
        input  task_valid, task_data, task_len, active_mask,
        output task_ready, disp_valid, disp_data, busy, gate_ok, task_count
    );

endinterface

// File: rtl/worker_slot.sv
// One worker slot: power/occupancy FSM plus remaining-cycle counter.
module worker_slot
    import worker_dispatch_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             grant,
    input  logic [LEN_W-1:0] len,
    output logic             eligible,
    output logic             busy,
    output logic             gate_ok
);

    slot_state_e      state, state_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_OFF;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            ST_OFF:  if (active) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_BUSY;
                    rem_nxt   = (len == '0) ? LEN_W'(1) : len;
                end else if (!active) begin
                    state_nxt = ST_OFF;
                end
            end
            ST_BUSY, ST_DRAIN: begin
                // A running task always finishes; the mask only picks where it lands.
                if (rem <= LEN_W'(1)) begin
                    rem_nxt   = '0;
                    state_nxt = (state == ST_BUSY) ? ST_IDLE : ST_OFF;
                end else begin
                    rem_nxt = rem - LEN_W'(1);
                    if (state == ST_BUSY && !active)      state_nxt = ST_DRAIN;
                    else if (state == ST_DRAIN && active) state_nxt = ST_BUSY;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    assign eligible = (state == ST_IDLE) && active;
    assign busy     = (state == ST_BUSY) || (state == ST_DRAIN);
    assign gate_ok  = (state == ST_OFF);

endmodule

// File: rtl/worker_dispatcher.sv
// Round-robin task dispatcher over NUM_WORKERS gateable worker slots.
module worker_dispatcher
    import worker_dispatch_pkg::*;
#(
    parameter int NUM_WORKERS = NUM_WORKERS_DEF,
    parameter int TASK_W      = TASK_W_DEF,
    parameter int LEN_W       = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    worker_dispatcher_if.slave bus
);

    localparam int IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    logic [NUM_WORKERS-1:0] eligible, grant_oh, busy_v, gate_v;
    logic [NUM_WORKERS-1:0] disp_valid_q;
    logic [TASK_W-1:0]      disp_data_q;
    logic [CNT_W-1:0]       task_count_q;
    logic [IDX_W-1:0]       last_grant, gidx;
    logic                   found, accept;

    for (genvar i = 0; i < NUM_WORKERS; i++) begin : g_slot
        worker_slot #(.LEN_W(LEN_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .active   (bus.active_mask[i]),
            .grant    (grant_oh[i]),
            .len      (bus.task_len),
            .eligible (eligible[i]),
            .busy     (busy_v[i]),
            .gate_ok  (gate_v[i])
        );
    end

    // Search starts one past the last winner so every eligible worker gets a turn.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 1; k <= NUM_WORKERS; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_WORKERS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = IDX_W'(idx);
            end
        end
    end

    assign accept = bus.task_valid && found;

    always_comb begin
        grant_oh = '0;
        if (accept) grant_oh[gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant   <= IDX_W'(NUM_WORKERS - 1);
            disp_valid_q <= '0;
            disp_data_q  <= '0;
            task_count_q <= '0;
        end else begin
            disp_valid_q <= grant_oh;
            if (accept) begin
                last_grant  <= gidx;
                disp_data_q <= bus.task_data;
                if (task_count_q != '1) task_count_q <= task_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.task_ready = found;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.busy       = busy_v;
    assign bus.gate_ok    = gate_v;
    assign bus.task_count = task_count_q;

endmodule

// File: tb/tb_worker_dispatcher.sv
// Directed bench for worker_dispatcher: reset, round-robin, stall, drain, zero length, mid-task reset.
module tb_worker_dispatcher;
    import worker_dispatch_pkg::*;

    localparam int NW = 4;
    localparam int TW = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    worker_dispatcher_if #(.NUM_WORKERS(NW), .TASK_W(TW), .LEN_W(LW)) bus ();

    worker_dispatcher #(.NUM_WORKERS(NW), .TASK_W(TW), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [TW-1:0] d, input logic [LW-1:0] l);
        bus.task_valid = 1'b1;
        bus.task_data  = d;
        bus.task_len   = l;
    endtask

    logic [TW-1:0] rr_data [4];
    logic [NW-1:0] rr_disp [7];
    logic [NW-1:0] rr_busy [7];

    initial begin
        rr_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        rr_disp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        rr_busy = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

        reset           = 1'b0;
        bus.task_valid  = 1'b0;
        bus.task_data   = '0;
        bus.task_len    = '0;
        bus.active_mask = '0;

        #2;
        chk("rst_gate",  bus.gate_ok,    4'hF);
        chk("rst_ready", bus.task_ready, 1'b0);
        chk("rst_busy",  bus.busy,       4'h0);
        chk("rst_disp",  bus.disp_valid, 4'h0);
        chk("rst_data",  bus.disp_data,  8'h00);
        chk("rst_cnt",   bus.task_count, 16'h0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_gate",  bus.gate_ok,    4'hF);
            chk("idle_ready", bus.task_ready, 1'b0);
            chk("idle_busy",  bus.busy,       4'h0);
        end

        // Round-robin across all four workers, len=3.
        bus.active_mask = 4'hF;
        tick();
        chk("rr_ready", bus.task_ready, 1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k < 4) offer(rr_data[k], 4'd3);
            else       bus.task_valid = 1'b0;
            tick();
            chk("rr_disp", bus.disp_valid, rr_disp[k]);
            if (k < 4) chk("rr_data", bus.disp_data, rr_data[k]);
            chk("rr_busy", bus.busy, rr_busy[k]);
        end
        chk("rr_cnt", bus.task_count, 16'd4);

        // Two workers, three len=5 tasks: third stalls until worker 0 frees.
        bus.active_mask = 4'b0011;
        chk("sat_ready0", bus.task_ready, 1'b1);
        offer(8'hA1, 4'd5);
        tick();
        chk("sat_disp0", bus.disp_valid, 4'b0001);
        chk("sat_data0", bus.disp_data,  8'hA1);
        offer(8'hA2, 4'd5);
        tick();
        chk("sat_disp1", bus.disp_valid, 4'b0010);
        chk("sat_data1", bus.disp_data,  8'hA2);
        chk("sat_gate",  bus.gate_ok,    4'b1100);
        chk("sat_stall", bus.task_ready, 1'b0);
        offer(8'hA3, 4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_stall", bus.task_ready, 1'b0);
            chk("sat_nodisp", bus.disp_valid, 4'b0000);
        end
        tick();
        chk("sat_free", bus.task_ready, 1'b1);
        chk("sat_nodisp", bus.disp_valid, 4'b0000);
        tick();
        chk("sat_disp2", bus.disp_valid, 4'b0001);
        chk("sat_data2", bus.disp_data,  8'hA3);
        bus.task_valid = 1'b0;
        chk("sat_cnt", bus.task_count, 16'd7);
        for (int i = 0; i < 6; i++) tick();

        // Only worker 2 powered; drop it mid-task and watch it drain to OFF.
        bus.active_mask = 4'b0100;
        tick();
        chk("drn_ready", bus.task_ready, 1'b1);
        chk("drn_gate0", bus.gate_ok,    4'b1011);
        offer(8'h5A, 4'd8);
        tick();
        chk("drn_disp", bus.disp_valid, 4'b0100);
        chk("drn_data", bus.disp_data,  8'h5A);
        chk("drn_busy", bus.busy,       4'b0100);
        bus.task_valid = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("drn_busy", bus.busy,    4'b0100);
            chk("drn_gate", bus.gate_ok, 4'b1011);
            if (c == 2) bus.active_mask = 4'b0000;
            else        chk("drn_ready", bus.task_ready, 1'b0);
        end
        tick();
        chk("drn_done_busy", bus.busy,    4'b0000);
        chk("drn_done_gate", bus.gate_ok, 4'b1111);
        chk("drn_cnt", bus.task_count, 16'd8);

        // task_len=0 occupies the worker for a single cycle.
        bus.active_mask = 4'b0001;
        tick();
        chk("z_ready", bus.task_ready, 1'b1);
        offer(8'h77, 4'd0);
        tick();
        bus.task_valid = 1'b0;
        chk("z_disp", bus.disp_valid, 4'b0001);
        chk("z_data", bus.disp_data,  8'h77);
        chk("z_busy", bus.busy,       4'b0001);
        tick();
        chk("z_busy_off", bus.busy,       4'b0000);
        chk("z_ready2",   bus.task_ready, 1'b1);
        chk("z_cnt",      bus.task_count, 16'd9);

        // Reset while a task runs and another is being accepted.
        bus.active_mask = 4'hF;
        tick();
        offer(8'h99, 4'd6);
        tick();
        chk("mr_busy", bus.busy,       4'b0010);
        chk("mr_disp", bus.disp_valid, 4'b0010);
        offer(8'hAA, 4'd6);
        reset = 1'b0;
        #1;
        chk("mr_disp0", bus.disp_valid, 4'h0);
        chk("mr_data0", bus.disp_data,  8'h00);
        chk("mr_busy0", bus.busy,       4'h0);
        chk("mr_gate0", bus.gate_ok,    4'hF);
        chk("mr_rdy0",  bus.task_ready, 1'b0);
        chk("mr_cnt0",  bus.task_count, 16'h0);
        tick();
        chk("mr_disp1", bus.disp_valid, 4'h0);
        chk("mr_busy1", bus.busy,       4'h0);
        bus.task_valid  = 1'b0;
        bus.active_mask = 4'h0;
        reset = 1'b1;
        tick();
        chk("mr_gate2", bus.gate_ok,    4'hF);
        chk("mr_rdy2",  bus.task_ready, 1'b0);
        chk("mr_cnt2",  bus.task_count, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
